// File: rtl/mem_access_stage_pkg.sv
// Shared types and helpers for the MEM stage: FSM states, funct3 codes, byte-enable generation.
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reserved encodings fall through to word access.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] a);
    case (f3_size(f3))
      SZ_B:    return a;
      SZ_H:    return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3_size(f3))
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Lane selection and sign/zero extension of load data by funct3 and the aligned low address bits.
module load_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'b0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'b0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: load/store over req/gnt/rvalid, stalls IE while busy, registered writeback.
// Optional misaligned-access trap enabled by MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int unsigned DMEM_ADDR_W = 32,
  parameter int unsigned WB_HOLD     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [31:0]            ex_alu_result,
  input  logic [31:0]            ex_rs2_value,
  input  logic [4:0]             ex_rd_addr,
  input  logic                   ex_rd_wen,
  input  logic                   ex_is_load,
  input  logic                   ex_is_store,
  input  logic [2:0]             ex_funct3,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [3:0]             dmem_be,
  output logic [31:0]            dmem_wdata,
  input  logic                   dmem_gnt,
  input  logic                   dmem_rvalid,
  input  logic [31:0]            dmem_rdata,
  output logic                   wb_valid,
  output logic                   wb_wen,
  output logic [4:0]             wb_rd_addr,
  output logic [31:0]            wb_data,
  output logic                   misalign_trap
);

  state_t      state;
  logic        is_load_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [4:0]  rd_q;
  logic        wen_q;

  logic        accept;
  logic        is_mem;
  logic        take_trap;
  size_t       sz;
  logic [1:0]  lo;
  logic [31:0] word_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;

  assign ex_ready = (state == IDLE);

  always_comb begin
    accept    = ex_valid && ex_ready;
    is_mem    = ex_is_load || ex_is_store;
    sz        = f3_size(ex_funct3);
    lo        = align_lo(ex_funct3, ex_alu_result[1:0]);
    word_addr = {ex_alu_result[31:2], 2'b00};
    case (sz)
      SZ_B:    store_data = {4{ex_rs2_value[7:0]}};
      SZ_H:    store_data = {2{ex_rs2_value[15:0]}};
      default: store_data = ex_rs2_value;
    endcase
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  always_comb begin
    take_trap = ((sz == SZ_H) && ex_alu_result[0]) ||
                ((sz == SZ_W) && (ex_alu_result[1:0] != 2'b00));
  end
`else
  always_comb begin
    take_trap = 1'b0;
  end
`endif

  load_align u_load_align (
    .funct3  (f3_q),
    .addr_lo (lo_q),
    .rdata   (dmem_rdata),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      is_load_q     <= 1'b0;
      f3_q          <= '0;
      lo_q          <= '0;
      rd_q          <= '0;
      wen_q         <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_wen        <= 1'b0;
      wb_rd_addr    <= '0;
      wb_data       <= '0;
      misalign_trap <= 1'b0;
    end else begin
      // Writeback fields are pulses unless the hold option keeps the last bundle visible.
      wb_valid      <= 1'b0;
      misalign_trap <= 1'b0;
      if (WB_HOLD == 0) begin
        wb_wen     <= 1'b0;
        wb_rd_addr <= '0;
        wb_data    <= '0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid   <= 1'b1;
              wb_wen     <= ex_rd_wen;
              wb_rd_addr <= ex_rd_addr;
              wb_data    <= ex_alu_result;
            end else if (take_trap) begin
              wb_valid      <= 1'b1;
              wb_wen        <= 1'b0;
              wb_rd_addr    <= ex_rd_addr;
              wb_data       <= '0;
              misalign_trap <= 1'b1;
            end else begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= !ex_is_load;
              dmem_addr  <= word_addr[DMEM_ADDR_W-1:0];
              dmem_be    <= calc_be(ex_funct3, ex_alu_result[1:0]);
              dmem_wdata <= store_data;
              is_load_q  <= ex_is_load;
              f3_q       <= ex_funct3;
              lo_q       <= lo;
              rd_q       <= ex_rd_addr;
              wen_q      <= ex_rd_wen;
            end
          end
        end

        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (is_load_q) begin
              state <= RESP;
            end else begin
              state      <= IDLE;
              wb_valid   <= 1'b1;
              wb_wen     <= 1'b0;
              wb_rd_addr <= rd_q;
              wb_data    <= '0;
            end
          end
        end

        RESP: begin
          if (dmem_rvalid) begin
            state      <= IDLE;
            wb_valid   <= 1'b1;
            wb_wen     <= wen_q;
            wb_rd_addr <= rd_q;
            wb_data    <= load_data;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a spec-level reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2_value;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_wen;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_wen;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        misalign_trap;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DMEM_ADDR_W(32), .WB_HOLD(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_rs2_value  (ex_rs2_value),
    .ex_rd_addr    (ex_rd_addr),
    .ex_rd_wen     (ex_rd_wen),
    .ex_is_load    (ex_is_load),
    .ex_is_store   (ex_is_store),
    .ex_funct3     (ex_funct3),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_wen        (wb_wen),
    .wb_rd_addr    (wb_rd_addr),
    .wb_data       (wb_data),
    .misalign_trap (misalign_trap)
  );

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value a load writes back, from byte-lane arithmetic on the memory word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata >> (8 * (addr % 4))) & 32'hFF;
    h = (rdata >> (8 * (addr & 32'd2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  task automatic scramble_ex();
    ex_alu_result = $urandom;
    ex_rs2_value  = $urandom;
    ex_rd_addr    = 5'($urandom);
    ex_rd_wen     = 1'($urandom);
    ex_is_load    = 1'($urandom);
    ex_is_store   = 1'($urandom);
    ex_funct3     = 3'($urandom);
  endtask

  task automatic clk_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one instruction at a negedge and follows it to writeback; returns at a negedge in IDLE.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic st, input logic [2:0] f3,
                        input int unsigned gd, input int unsigned rvd, input logic [31:0] rdata);
    int unsigned sz;
    logic [31:0] lo, ebe, ewd, eaddr;
    bit mis, trap, mem;
    mem = ld || st;
    sz = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    mis = (alu % sz) != 0;
    lo = (sz == 1) ? alu % 4 : (sz == 2) ? (alu & 32'd2) : 32'd0;
    ebe = (sz == 1) ? (32'd1 << lo) : (sz == 2) ? (32'd3 << lo) : 32'd15;
    ewd = (sz == 1) ? rs2[7:0] * 32'h0101_0101 : (sz == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
    eaddr = alu & ~32'd3;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    trap = mem && mis;
`else
    trap = 1'b0;
`endif

    ex_valid = 1'b1; ex_alu_result = alu; ex_rs2_value = rs2; ex_rd_addr = rd;
    ex_rd_wen = wen; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    chk_b("ready_at_issue", ex_ready, 1'b1);
    clk_step();
    ex_valid = 1'b0;
    scramble_ex();

    if (!mem || trap) begin
      chk_b("wb_valid_n1", wb_valid, 1'b1);
      chk_b("wb_wen_n1", wb_wen, trap ? 1'b0 : wen);
      chk_b("trap_n1", misalign_trap, trap);
      chk_b("no_req", dmem_req, 1'b0);
      chk_b("ready_n1", ex_ready, 1'b1);
      if (!trap) begin
        chk_w("wb_rd_alu", {27'b0, wb_rd_addr}, {27'b0, rd});
        chk_w("wb_data_alu", wb_data, alu);
      end
      return;
    end

    for (int unsigned k = 0; k <= gd; k++) begin
      chk_b("req_held", dmem_req, 1'b1);
      chk_b("req_we", dmem_we, !ld);
      chk_w("req_addr", dmem_addr, eaddr);
      chk_w("req_be", {28'b0, dmem_be}, ebe);
      if (!ld) chk_w("req_wdata", dmem_wdata, ewd);
      chk_b("ready_req", ex_ready, 1'b0);
      chk_b("wb_idle_req", wb_valid, 1'b0);
      chk_w("wb_data_cleared", wb_data, 32'd0);
      chk_b("trap_req", misalign_trap, 1'b0);
      dmem_gnt = (k == gd);
      clk_step();
    end
    dmem_gnt = 1'b0;

    if (!ld) begin
      chk_b("st_wb_valid", wb_valid, 1'b1);
      chk_b("st_wb_wen", wb_wen, 1'b0);
      chk_b("st_req_drop", dmem_req, 1'b0);
      chk_b("st_ready", ex_ready, 1'b1);
      return;
    end

    for (int unsigned k = 0; k <= rvd; k++) begin
      chk_b("resp_req_low", dmem_req, 1'b0);
      chk_b("ready_resp", ex_ready, 1'b0);
      chk_b("wb_idle_resp", wb_valid, 1'b0);
      dmem_gnt    = 1'($urandom);
      dmem_rvalid = (k == rvd);
      dmem_rdata  = (k == rvd) ? rdata : $urandom;
      clk_step();
    end
    dmem_rvalid = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rdata  = $urandom;
    chk_b("ld_wb_valid", wb_valid, 1'b1);
    chk_b("ld_wb_wen", wb_wen, wen);
    chk_w("ld_wb_rd", {27'b0, wb_rd_addr}, {27'b0, rd});
    chk_w("ld_wb_data", wb_data, ref_load(f3, alu, rdata));
    chk_b("ld_ready", ex_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0;
    ex_alu_result = '0; ex_rs2_value = '0; ex_rd_addr = '0; ex_rd_wen = 1'b0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_funct3 = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    #1;
    chk_b("rst_req", dmem_req, 1'b0);
    chk_b("rst_we", dmem_we, 1'b0);
    chk_w("rst_addr", dmem_addr, 32'd0);
    chk_w("rst_be", {28'b0, dmem_be}, 32'd0);
    chk_w("rst_wdata", dmem_wdata, 32'd0);
    chk_b("rst_wb_valid", wb_valid, 1'b0);
    chk_b("rst_wb_wen", wb_wen, 1'b0);
    chk_w("rst_wb_rd", {27'b0, wb_rd_addr}, 32'd0);
    chk_w("rst_wb_data", wb_data, 32'd0);
    chk_b("rst_trap", misalign_trap, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_b("ready_after_rst", ex_ready, 1'b1);

    // Stray gnt/rvalid while idle must do nothing.
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
    clk_step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk_b("idle_gnt_req", dmem_req, 1'b0);
    chk_b("idle_rvalid_wb", wb_valid, 1'b0);
    chk_b("idle_ready", ex_ready, 1'b1);

    run_op(32'h0000_1234, $urandom, 5'd5, 1'b1, 1'b0, 1'b0, 3'b010, 0, 0, 32'd0);
    run_op(32'h0000_0103, 32'hAABB_CCDD, 5'd7, 1'b1, 1'b0, 1'b1, 3'b000, 3, 0, 32'd0);
    run_op(32'h0000_0202, $urandom, 5'd9, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0, 32'h1280_3456);
    run_op(32'h0000_0202, $urandom, 5'd10, 1'b1, 1'b1, 1'b0, 3'b101, 0, 0, 32'h1280_3456);
    run_op(32'h0000_0400, $urandom, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010, 0, 2, $urandom);
    run_op(32'h0000_0301, $urandom, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010, 0, 0, $urandom);
    run_op(32'h0000_0107, $urandom, 5'd0, 1'b1, 1'b1, 1'b0, 3'b000, 1, 1, 32'h8000_0000);
    run_op(32'h0000_0806, 32'h1122_8344, 5'd12, 1'b1, 1'b1, 1'b1, 3'b001, 0, 0, 32'h8123_4567);
    run_op(32'h0000_0502, 32'hCAFE_F00D, 5'd13, 1'b1, 1'b0, 1'b1, 3'b011, 2, 0, 32'd0);
    run_op(32'h0000_0a03, 32'h0000_00F1, 5'd14, 1'b0, 1'b0, 1'b1, 3'b001, 0, 0, 32'd0);

    // Reset while a request is pending: dmem_req must drop without a clock edge.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
    ex_alu_result = 32'h600; ex_rd_addr = 5'd4; ex_rd_wen = 1'b1;
    clk_step();
    ex_valid = 1'b0;
    chk_b("pre_rst_req", dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_b("rst_req_drop", dmem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_b("ready_after_req_rst", ex_ready, 1'b1);

    // Reset in RESP, then a late rvalid must be ignored.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
    ex_alu_result = 32'h700; ex_rd_addr = 5'd6; ex_rd_wen = 1'b1;
    clk_step();
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    clk_step();
    dmem_gnt = 1'b0;
    chk_b("resp_ready_low", ex_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_b("rst_resp_wb", wb_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
    clk_step();
    dmem_rvalid = 1'b0;
    chk_b("late_rvalid_wb", wb_valid, 1'b0);
    chk_b("late_rvalid_ready", ex_ready, 1'b1);
    chk_b("late_rvalid_req", dmem_req, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      run_op($urandom, $urandom, 5'($urandom), 1'($urandom),
             (kind == 1) || (kind == 3), (kind == 2) || (kind == 3), 3'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the pipelined core, directly downstream of the IE stage ALU.
- Consumes the ALU result, the rs2 value and the destination info.
- Performs load/store to data memory over a req/gnt/rvalid handshake and stalls IE while a transfer is outstanding.
- Produces the registered writeback bundle that feeds the register-file write mux.

Parameters:
- DMEM_ADDR_W, 32, width of the data-memory byte address.
- WB_HOLD, 0, if 1 then wb_* hold their last value when wb_valid=0; if 0 then wb_data/wb_rd_addr are cleared to 0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  IE presents an instruction
- ex_ready  out  1  stage can accept; IE stalls when low
- ex_alu_result  in  32  ALU result / effective address
- ex_rs2_value  in  32  store data
- ex_rd_addr  in  5  destination register
- ex_rd_wen  in  1  instruction writes rd
- ex_is_load  in  1  load instruction
- ex_is_store  in  1  store instruction
- ex_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DMEM_ADDR_W  word-aligned address (bits[1:0] = 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- wb_valid  out  1  writeback bundle valid (one-cycle pulse)
- wb_wen  out  1  register-file write enable
- wb_rd_addr  out  5  writeback destination
- wb_data  out  32  writeback data
- misalign_trap  out  1  misaligned-access pulse; tied 0 without the optional feature

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, except ex_ready=1 once rst_n deasserts.
  - Any in-flight transfer is abandoned; dmem_req drops immediately.
- FSM states: IDLE, REQ, RESP.
  - ex_ready = (state==IDLE).
  - Accept when ex_valid && ex_ready.
- Non-memory op accepted at edge N: wb_valid=1 in cycle N+1; wb_data=ex_alu_result; wb_wen=ex_rd_wen; stays IDLE.
- Memory op accepted at edge N → REQ.
  - From cycle N+1: dmem_req=1. Address, we, be and wdata are registered and held stable until gnt.
- REQ with dmem_gnt=1:
  - Store → IDLE; wb_valid pulse with wb_wen=0 the next cycle.
  - Load → RESP.
- RESP:
  - dmem_req=0; wait for dmem_rvalid (unbounded).
  - On rvalid: wb_valid pulse next cycle, wb_wen=ex_rd_wen, wb_data = aligned/extended dmem_rdata; → IDLE.
- Minimum latencies: store with immediate gnt, wb_valid at N+2; load with gnt at N+1 and rvalid at N+2, wb_valid at N+3.
- Handshake rules:
  - dmem_rvalid in IDLE/REQ is ignored (covers a late response after reset).
  - dmem_gnt outside REQ is ignored.
  - dmem_rvalid never arrives in the same cycle as its gnt.
- Store lanes:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=rs2, be=4'b1111.
- Load extraction:
  - Select the byte/half by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Reserved funct3 values (011, 110, 111) are treated as word access.
- ex_is_load && ex_is_store both set: handled as a load.
- x0 destination: wb_rd_addr=0 is passed through unchanged; the register file ignores it.

Optional Feature:
- Macro MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - A halfword at addr[0]=1, or a word at addr[1:0]≠0, issues no dmem_req.
  - misalign_trap pulses 1 cycle at N+1 together with wb_valid=1, wb_wen=0; stays IDLE.
- Undefined:
  - Low address bits are forced aligned: half uses addr[1] only, word uses 0.
  - misalign_trap is constant 0.

Decomposition:
- Package mem_access_pkg:
  - State enum (IDLE/REQ/RESP).
  - funct3 localparams.
  - Function computing be from funct3/addr[1:0].
- Sub-module load_align: combinational extraction and sign/zero extension of dmem_rdata by funct3 and addr[1:0].

Test Plan:
- ALU op, ex_alu_result=0x0000_1234, rd=5, wen=1 → wb_valid at N+1, wb_data=0x1234, wb_rd_addr=5, no dmem_req.
- SB, addr=0x103, rs2=0xAABBCCDD, gnt after 3 stall cycles:
  - dmem_req held 3 cycles; addr=0x100, be=4'b1000, wdata=0xDDDDDDDD.
  - ex_ready=0 throughout; wb_wen=0.
- LB, addr=0x202, rdata=0x1280_3456 → wb_data=0xFFFF_FF80.
- LHU at the same address and data → wb_data=0x0000_1280.
- LW with gnt at N+1 and rvalid at N+4 → wb_valid exactly at N+5; ex_ready low N+1..N+4.
- Assert rst_n=0 while in RESP, then rvalid=1 after release → no wb_valid, state IDLE, ex_ready=1.
- With MEM_ACCESS_MISALIGN_TRAP_EN, LW at addr=0x301 → misalign_trap=1 at N+1, no dmem_req.
- Without the macro, the same LW → dmem_addr=0x300, be=4'b1111.
